// File: rtl/spi_master.sv
// SPI master with per-device selects, CPOL/CPHA, selectable bit order and a
// one-deep transmit holding register so that consecutive bytes run with no gap.
//
//   state | meaning
//   IDLE  | no byte in flight; SCK parked at CPOL, MOSI high, control writes accepted
//   SHIFT | one byte in flight (16 SCK edges); a further byte may wait in the holding register
module spi_master #(
    parameter int NSS  = 2,
    parameter int HALF = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           WR_CTRL,
    input  logic           WR_DATA,
    input  logic           RD_ACK,
    input  logic [7:0]     DIN,
    input  logic [NSS-1:0] MISO,
    output logic           MOSI,
    output logic           SCK,
    output logic [NSS-1:0] nSS,
    output logic [7:0]     RXD,
    output logic           RXVALID,
    output logic           BUSY,
    output logic           TXFULL,
    output logic           OVR
);

    localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [TW-1:0] T_RELOAD = TW'(HALF - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [7:0]     ctrl;
    logic           cpha;
    logic           cpol;
    logic           lsb_first;
    logic [NSS-1:0] mask;
    logic           ctrl_unused;

    logic [TW-1:0]  timer;
    logic [3:0]     edge_cnt;
    logic [7:0]     tx_sr;
    logic [7:0]     rx_sr;
    logic [7:0]     hold;

    logic           sin;
    logic           tick;
    logic           last_edge;
    logic           leading;
    logic           sample;
    logic           present;
    logic           start;
    logic           chain;
    logic           load;
    logic           ctrl_wr;
    logic           ovr_set;
    logic [7:0]     load_byte;
    logic [7:0]     rx_shift;

    function automatic logic first_bit(input logic [7:0] b, input logic lsb);
        return lsb ? b[0] : b[7];
    endfunction

    function automatic logic [7:0] drop_bit(input logic [7:0] b, input logic lsb);
        return lsb ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
    endfunction

    assign cpha        = ctrl[0];
    assign cpol        = ctrl[1];
    assign lsb_first   = ctrl[2];
    assign mask        = ctrl[3+NSS:4];
    assign ctrl_unused = ^ctrl;
    assign nSS         = ~mask;

    assign sin       = |(MISO & mask);
    assign tick      = (state == SHIFT) && (timer == '0);
    assign last_edge = tick && (edge_cnt == 4'd15);
    // edge_cnt counts edges already made, so an even count means the coming edge is odd (leading)
    assign leading   = ~edge_cnt[0];
    assign sample    = tick && (cpha ? !leading : leading);
    assign present   = tick && !last_edge && (cpha ? leading : !leading);

    // A data write wins over a control write in the same IDLE cycle: the engine is busy from then on.
    assign ctrl_wr   = (state == IDLE) && WR_CTRL && !WR_DATA;
    assign start     = (state == IDLE) && WR_DATA;
    assign chain     = last_edge && (TXFULL || WR_DATA);
    assign load      = start || chain;
    assign load_byte = TXFULL ? hold : DIN;
    assign rx_shift  = lsb_first ? {sin, rx_sr[7:1]} : {rx_sr[6:0], sin};
    assign ovr_set   = (WR_DATA && TXFULL) || (last_edge && RXVALID && !RD_ACK);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (WR_DATA) state_nx = SHIFT;
            SHIFT:   if (last_edge && !(TXFULL || WR_DATA)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl     <= 8'h00;
            timer    <= T_RELOAD;
            edge_cnt <= 4'd0;
            tx_sr    <= 8'h00;
            rx_sr    <= 8'h00;
            hold     <= 8'h00;
            SCK      <= 1'b0;
            MOSI     <= 1'b1;
            RXD      <= 8'h00;
            RXVALID  <= 1'b0;
            BUSY     <= 1'b0;
            TXFULL   <= 1'b0;
            OVR      <= 1'b0;
        end else begin
            BUSY <= (state_nx == SHIFT);

            if (ctrl_wr) ctrl <= DIN;

            if (load) begin
                timer    <= T_RELOAD;
                edge_cnt <= 4'd0;
            end else if (tick) begin
                timer    <= T_RELOAD;
                edge_cnt <= edge_cnt + 4'd1;
            end else if (state == SHIFT) begin
                timer    <= timer - 1'b1;
            end

            // Sixteen toggles per byte bring SCK back to CPOL on the completion edge.
            if (state == IDLE) SCK <= ctrl_wr ? DIN[1] : cpol;
            else if (tick)     SCK <= ~SCK;

            if (load) begin
                if (!cpha) begin
                    MOSI  <= first_bit(load_byte, lsb_first);
                    tx_sr <= drop_bit(load_byte, lsb_first);
                end else begin
                    tx_sr <= load_byte;
                end
            end else if (present) begin
                MOSI  <= first_bit(tx_sr, lsb_first);
                tx_sr <= drop_bit(tx_sr, lsb_first);
            end else if (last_edge) begin
                MOSI  <= 1'b1;
            end

            if (load)        rx_sr <= 8'h00;
            else if (sample) rx_sr <= rx_shift;

            // With CPHA=1 the eighth bit is sampled on the completion edge itself.
            if (last_edge) begin
                RXD     <= cpha ? rx_shift : rx_sr;
                RXVALID <= 1'b1;
            end else if (RD_ACK) begin
                RXVALID <= 1'b0;
            end

            if (last_edge) begin
                TXFULL <= 1'b0;
            end else if ((state == SHIFT) && WR_DATA && !TXFULL) begin
                hold   <= DIN;
                TXFULL <= 1'b1;
            end

            if (ctrl_wr)      OVR <= 1'b0;
            else if (ovr_set) OVR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a slave model on MISO[1], loopback on MISO[0], and a
// scoreboard monitor that checks every completed byte against queued expectations.
module tb_spi_master;

    localparam int NSS  = 2;
    localparam int HALF = 2;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           WR_CTRL = 1'b0;
    logic           WR_DATA = 1'b0;
    logic           RD_ACK = 1'b0;
    logic [7:0]     DIN = 8'h00;
    logic [NSS-1:0] MISO;
    logic           MOSI;
    logic           SCK;
    logic [NSS-1:0] nSS;
    logic [7:0]     RXD;
    logic           RXVALID;
    logic           BUSY;
    logic           TXFULL;
    logic           OVR;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];

    logic           cur_cpha = 1'b0;
    logic           cur_cpol = 1'b0;
    logic           cur_lsb  = 1'b0;
    logic [NSS-1:0] cur_mask = '0;
    logic [7:0]     slave_byte = 8'h00;
    logic           slave_bit = 1'b0;

    logic       prev_sck = 1'b0;
    logic       prev_mosi = 1'b1;
    logic       prev_busy = 1'b0;
    logic       prev_rst = 1'b1;
    int         e = 0;
    int         j = 0;
    logic [7:0] srx = 8'h00;
    logic [7:0] er;
    logic [7:0] et;

    assign MISO = {slave_bit, MOSI};

    spi_master #(.NSS(NSS), .HALF(HALF)) dut (
        .CLK(CLK), .RST(RST), .WR_CTRL(WR_CTRL), .WR_DATA(WR_DATA), .RD_ACK(RD_ACK),
        .DIN(DIN), .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .nSS(nSS), .RXD(RXD),
        .RXVALID(RXVALID), .BUSY(BUSY), .TXFULL(TXFULL), .OVR(OVR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] slv,
                                            input logic [NSS-1:0] m);
        return (m[0] ? tx : 8'h00) | (m[1] ? slv : 8'h00);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_ctrl(input logic [7:0] v);
        WR_CTRL = 1'b1;
        DIN = v;
        cur_cpha = v[0];
        cur_cpol = v[1];
        cur_lsb  = v[2];
        cur_mask = v[3+NSS:4];
        tick();
        WR_CTRL = 1'b0;
    endtask

    task automatic write_data(input logic [7:0] v);
        WR_DATA = 1'b1;
        DIN = v;
        tick();
        WR_DATA = 1'b0;
    endtask

    task automatic rd_ack();
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] tx);
        exp_rx_q.push_back(model_rx(tx, slave_byte, cur_mask));
        exp_tx_q.push_back(tx);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (BUSY && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", BUSY, 1'b0);
    endtask

    // Slave side of the link: counts SCK edges of a byte, captures MOSI on the
    // receiver's sampling edges and shifts slave_byte out on MISO[1].
    always @(negedge CLK) begin
        if (RST || prev_rst) begin
            e   = 0;
            srx = 8'h00;
        end else if ((SCK !== prev_sck) && prev_busy) begin
            e++;
            if (((e % 2) == 1) == !cur_cpha)
                srx = cur_lsb ? {prev_mosi, srx[7:1]} : {srx[6:0], prev_mosi};
            if (e == 16) begin
                e = 0;
                check("sb_nonempty", (exp_rx_q.size() > 0), 1'b1);
                if (exp_rx_q.size() > 0) begin
                    er = exp_rx_q.pop_front();
                    et = exp_tx_q.pop_front();
                    check("rxd", RXD, er);
                    check("rxvalid", RXVALID, 1'b1);
                    check("mosi_byte", srx, et);
                end
                srx = 8'h00;
            end
        end
        j = cur_cpha ? (e / 2) : ((e + 1) / 2);
        if (j < 8) slave_bit = cur_lsb ? slave_byte[j] : slave_byte[7-j];
        else       slave_bit = 1'b0;
        prev_sck  = SCK;
        prev_mosi = MOSI;
        prev_busy = BUSY;
        prev_rst  = RST;
    end

    initial begin
        logic [NSS-1:0] exp_nss;
        logic [7:0] c;
        logic [7:0] tx;
        logic [7:0] tx2;
        logic last_sck;
        int tgl;
        int n;
        int d;

        tick();
        tick();
        RST = 1'b0;
        check("rst_sck", SCK, 1'b0);
        check("rst_mosi", MOSI, 1'b1);
        check("rst_nss", nSS, 2'b11);
        check("rst_busy", BUSY, 1'b0);
        check("rst_rxd", RXD, 8'h00);
        check("rst_rxvalid", RXVALID, 1'b0);
        check("rst_txfull", TXFULL, 1'b0);
        check("rst_ovr", OVR, 1'b0);

        write_ctrl(8'h10);
        check("nss_after_ctrl", nSS, 2'b10);

        // Mode 0, MSB first, device 0 loopback
        expect_byte(8'hA5);
        write_data(8'hA5);
        check("m0_first_mosi", MOSI, 1'b1);
        check("m0_busy_rise", BUSY, 1'b1);
        check("m0_sck_start", SCK, 1'b0);
        tgl = 0;
        last_sck = SCK;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (SCK !== last_sck) tgl++;
            last_sck = SCK;
        end
        check("m0_busy_before_end", BUSY, 1'b1);
        check("m0_rxvalid_before_end", RXVALID, 1'b0);
        tick();
        if (SCK !== last_sck) tgl++;
        check("m0_sck_toggles", tgl, 16);
        check("m0_busy_end", BUSY, 1'b0);
        check("m0_rxvalid_end", RXVALID, 1'b1);
        check("m0_rxd_end", RXD, 8'hA5);
        check("m0_mosi_idle", MOSI, 1'b1);
        rd_ack();
        check("m0_rxvalid_acked", RXVALID, 1'b0);

        // Mode 3, LSB first, device 1 slave
        write_ctrl(8'h27);
        check("m3_sck_idle_before", SCK, 1'b1);
        check("m3_nss", nSS, 2'b01);
        slave_byte = 8'h3C;
        expect_byte(8'h00);
        write_data(8'h00);
        wait_idle(100);
        check("m3_rxd", RXD, 8'h3C);
        check("m3_sck_idle_after", SCK, 1'b1);
        rd_ack();

        // Back-to-back bytes with an acknowledge between them
        write_ctrl(8'h10);
        expect_byte(8'h11);
        expect_byte(8'h22);
        write_data(8'h11);
        n = 1;
        for (int i = 0; i < 200 && BUSY; i++) begin
            if (i == 3) begin
                WR_DATA = 1'b1;
                DIN = 8'h22;
            end
            if (i == 40) RD_ACK = 1'b1;
            tick();
            WR_DATA = 1'b0;
            RD_ACK = 1'b0;
            if (i == 3) check("b2b_txfull", TXFULL, 1'b1);
            if (BUSY) n++;
        end
        check("b2b_busy_len", n, 64);
        check("b2b_txfull_clear", TXFULL, 1'b0);
        check("b2b_no_ovr", OVR, 1'b0);
        rd_ack();

        // Overrun by a third write while the holding register is full
        expect_byte(8'h44);
        expect_byte(8'h55);
        write_data(8'h44);
        tick();
        write_data(8'h55);
        write_data(8'h66);
        check("ovr_drop_txfull", TXFULL, 1'b1);
        check("ovr_drop_set", OVR, 1'b1);
        wait_idle(200);
        check("ovr_after", OVR, 1'b1);
        check("ovr_rxd_newest", RXD, 8'h55);
        write_ctrl(8'h10);
        check("ovr_cleared", OVR, 1'b0);

        // Overrun by an unacknowledged completion
        expect_byte(8'h77);
        write_data(8'h77);
        wait_idle(100);
        check("ovr_unacked", OVR, 1'b1);
        check("ovr_unacked_rxd", RXD, 8'h77);
        write_ctrl(8'h10);

        // Acknowledge on the completion edge: new data wins, no overrun
        expect_byte(8'h88);
        write_data(8'h88);
        for (int i = 0; i < 31; i++) tick();
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        check("ackcomp_busy", BUSY, 1'b0);
        check("ackcomp_rxvalid", RXVALID, 1'b1);
        check("ackcomp_ovr", OVR, 1'b0);
        rd_ack();

        // Reset at the seventh SCK edge with a byte waiting
        write_ctrl(8'h13);
        write_data(8'h99);
        WR_DATA = 1'b1;
        DIN = 8'hAA;
        tick();
        WR_DATA = 1'b0;
        check("rstmid_txfull", TXFULL, 1'b1);
        for (int i = 0; i < 12; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rstmid_sck", SCK, 1'b0);
        check("rstmid_mosi", MOSI, 1'b1);
        check("rstmid_nss", nSS, 2'b11);
        check("rstmid_busy", BUSY, 1'b0);
        check("rstmid_txfull0", TXFULL, 1'b0);
        check("rstmid_rxd", RXD, 8'h00);
        check("rstmid_rxvalid", RXVALID, 1'b0);
        check("rstmid_ovr", OVR, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        check("rstmid_hold_dropped", BUSY, 1'b0);
        write_ctrl(8'h10);
        expect_byte(8'h5A);
        write_data(8'h5A);
        wait_idle(100);
        check("rstmid_new_rxd", RXD, 8'h5A);
        rd_ack();

        // Randomized modes, masks, orders and data
        for (int it = 0; it < 30; it++) begin
            c = 8'($urandom);
            write_ctrl(c);
            exp_nss = ~cur_mask;
            check("rand_nss", nSS, exp_nss);
            check("rand_sck_idle", SCK, cur_cpol);
            slave_byte = 8'($urandom);
            tx = 8'($urandom);
            expect_byte(tx);
            write_data(tx);
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom_range(1, 20);
                for (int k = 0; k < d; k++) tick();
                tx2 = 8'($urandom);
                expect_byte(tx2);
                write_data(tx2);
            end
            wait_idle(300);
            check("rand_sck_park", SCK, cur_cpol);
            rd_ack();
        end

        tick();
        check("sb_empty", exp_rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
